// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALUOp classes,
// mux select codes and the sequencer state encoding. Optional JAL support: MULTICYCLE_JAL_EN.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;

    localparam logic [OPCODE_W-1:0] OpcR    = 6'b000000;
    localparam logic [OPCODE_W-1:0] OpcLw   = 6'b100011;
    localparam logic [OPCODE_W-1:0] OpcSw   = 6'b101011;
    localparam logic [OPCODE_W-1:0] OpcBeq  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OpcBne  = 6'b000101;
    localparam logic [OPCODE_W-1:0] OpcAddi = 6'b001000;
    localparam logic [OPCODE_W-1:0] OpcOri  = 6'b001101;
    localparam logic [OPCODE_W-1:0] OpcLui  = 6'b001111;
    localparam logic [OPCODE_W-1:0] OpcJ    = 6'b000010;
    localparam logic [OPCODE_W-1:0] OpcJal  = 6'b000011;

    // Class codes shared with the ALU control decoder.
    localparam logic [ALUOP_W-1:0] AluOpRtype  = 3'b111;
    localparam logic [ALUOP_W-1:0] AluOpLui    = 3'b110;
    localparam logic [ALUOP_W-1:0] AluOpOri    = 3'b101;
    localparam logic [ALUOP_W-1:0] AluOpAdd    = 3'b100;
    localparam logic [ALUOP_W-1:0] AluOpBranch = 3'b011;
    localparam logic [ALUOP_W-1:0] AluOpMem    = 3'b010;

    localparam logic [1:0] SrcBRt     = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRead = 4'd3,
        StMemWb   = 4'd4,
        StMemWrite = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StJalLink = 4'd11
    } state_e;

    // Successor of DECODE; StFetch doubles as the illegal-opcode exit.
    function automatic state_e decode_next(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OpcLw, OpcSw:             return StMemAddr;
            OpcR:                     return StExecR;
            OpcAddi, OpcOri, OpcLui:  return StExecI;
            OpcBeq, OpcBne:           return StBranch;
            OpcJ:                     return StJump;
`ifdef MULTICYCLE_JAL_EN
            OpcJal:                   return StJalLink;
`endif
            default:                  return StFetch;
        endcase
    endfunction

    function automatic logic opcode_known(input logic [OPCODE_W-1:0] opc);
        return decode_next(opc) != StFetch;
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-output decoder for the multi-cycle sequencer.
// MULTICYCLE_JAL_EN adds the JAL_LINK state decode and the link output.
module multicycle_control_decode
    import mips_pkg::*;
(
    input  state_e               state_i,
    input  logic [OPCODE_W-1:0]  opcode_i,
    input  logic                 zero_i,
    output logic [ALUOP_W-1:0]   alu_op_o,
    output logic                 alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic                 pc_write_o,
    output logic                 ir_write_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 reg_write_o,
    output logic                 iord_o,
    output logic [1:0]           pc_src_o,
    output logic                 reg_dst_o,
    output logic                 mem_to_reg_o,
    output logic                 illegal_o
`ifdef MULTICYCLE_JAL_EN
    ,
    output logic                 link_o
`endif
);

    always_comb begin
        alu_op_o     = '0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SrcBRt;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        iord_o       = 1'b0;
        pc_src_o     = PcSrcAlu;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        illegal_o    = 1'b0;
`ifdef MULTICYCLE_JAL_EN
        link_o       = 1'b0;
`endif
        unique case (state_i)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SrcBFour;
                alu_op_o    = AluOpAdd;
                // Write enables are gated by mem_ready in the top.
                ir_write_o  = 1'b1;
                pc_write_o  = 1'b1;
            end
            StDecode: begin
                alu_src_b_o = SrcBImmSh2;
                alu_op_o    = AluOpAdd;
                illegal_o   = !opcode_known(opcode_i);
            end
            StMemAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBImm;
                alu_op_o    = AluOpMem;
            end
            StMemRead: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            StMemWrite: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            StExecR: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = AluOpRtype;
            end
            StExecI: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBImm;
                case (opcode_i)
                    OpcOri:  alu_op_o = AluOpOri;
                    OpcLui:  alu_op_o = AluOpLui;
                    default: alu_op_o = AluOpAdd;
                endcase
            end
            StAluWb: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (opcode_i == OpcR);
            end
            StBranch: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = AluOpBranch;
                pc_src_o    = PcSrcAluOut;
                pc_write_o  = ((opcode_i == OpcBeq) && zero_i) ||
                              ((opcode_i == OpcBne) && !zero_i);
            end
            StJump: begin
                pc_src_o   = PcSrcJump;
                pc_write_o = 1'b1;
            end
`ifdef MULTICYCLE_JAL_EN
            StJalLink: begin
                // src_b=00 is a zero operand here, so ALU output is the PC.
                alu_op_o    = AluOpAdd;
                reg_write_o = 1'b1;
                link_o      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register and next-state logic around the output decoder.
// MULTICYCLE_JAL_EN enables JAL (opcode 000011) and the link output.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic [ALUOP_W-1:0]   alu_op,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 iord,
    output logic [1:0]           pc_src,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 illegal
`ifdef MULTICYCLE_JAL_EN
    ,
    output logic                 link
`endif
);

    state_e state_q, state_d, dec_state;
    logic   dec_pc_write, dec_ir_write;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode:   state_d = decode_next(opcode);
            StMemAddr:  state_d = (opcode == OpcLw) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJump:     state_d = StFetch;
            StJalLink:  state_d = StJump;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoding FETCH while in reset suppresses any in-flight store or write-back.
    assign dec_state = reset ? StFetch : state_q;

    multicycle_control_decode u_decode (
        .state_i      (dec_state),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .alu_op_o     (alu_op),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .pc_write_o   (dec_pc_write),
        .ir_write_o   (dec_ir_write),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .reg_write_o  (reg_write),
        .iord_o       (iord),
        .pc_src_o     (pc_src),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .illegal_o    (illegal)
`ifdef MULTICYCLE_JAL_EN
        ,
        .link_o       (link)
`endif
    );

    // FETCH commits the instruction only once memory delivers it.
    always_comb begin
        pc_write = dec_pc_write;
        ir_write = dec_ir_write;
        if (dec_state == StFetch) begin
            pc_write = dec_pc_write && mem_ready && !reset;
            ir_write = dec_ir_write && mem_ready && !reset;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: builds a per-cycle expected output schedule per instruction.
// Define MULTICYCLE_JAL_EN to also exercise JAL and the link output.
module tb_multicycle_control;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpLui  = 6'b001111;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpJal  = 6'b000011;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, iord;
    logic [1:0] pc_src;
    logic       reg_dst, mem_to_reg, illegal;
    logic       link_w;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .iord       (iord),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
`ifdef MULTICYCLE_JAL_EN
        ,
        .link       (link_w)
`endif
    );

`ifndef MULTICYCLE_JAL_EN
    assign link_w = 1'b0;
`endif

    logic [31:0] obs;
    assign obs = {14'b0, link_w, alu_op, alu_src_a, alu_src_b, pc_write, ir_write, mem_read,
                  mem_write, reg_write, iord, pc_src, reg_dst, mem_to_reg, illegal};

    typedef struct {
        logic        rst;
        logic        mr;
        logic [5:0]  opc;
        logic        z;
        logic [31:0] exp;
        string       tag;
    } step_t;

    step_t sched[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    function automatic logic [31:0] w(input logic [2:0] aop, input logic sa,
                                      input logic [1:0] sb, input logic pcw, input logic irw,
                                      input logic mrd, input logic mwr, input logic rw,
                                      input logic io, input logic [1:0] ps, input logic rd,
                                      input logic m2r, input logic ill, input logic lk);
        return {14'b0, lk, aop, sa, sb, pcw, irw, mrd, mwr, rw, io, ps, rd, m2r, ill};
    endfunction

    function automatic logic legal(input logic [5:0] opc);
        case (opc)
            OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpOri, OpLui, OpJ: return 1'b1;
`ifdef MULTICYCLE_JAL_EN
            OpJal: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic rst, input logic mr, input logic [5:0] opc, input logic z,
                        input logic [31:0] exp, input string tag);
        step_t s;
        s.rst = rst; s.mr = mr; s.opc = opc; s.z = z; s.exp = exp; s.tag = tag;
        sched.push_back(s);
    endtask

    task automatic push_fetch(input int fw);
        for (int i = 0; i < fw; i++)
            push(0, 0, 6'($urandom), 1'($urandom),
                 w(3'b100, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "fetch_wait");
        push(0, 1, 6'($urandom), 1'($urandom),
             w(3'b100, 0, 2'b01, 1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "fetch");
    endtask

    // Everything after FETCH; abort_sw stops an SW in its write wait with a reset cycle.
    task automatic push_body(input logic [5:0] opc, input logic z, input int mw,
                             input bit abort_sw);
        logic [5:0] o;
        o = opc;
        push(0, 1'($urandom), o, 1'($urandom),
             w(3'b100, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, !legal(o), 0), "decode");
        if (!legal(o)) return;
        case (o)
            OpLw, OpSw: begin
                push(0, 1'($urandom), o, 1'($urandom),
                     w(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "mem_addr");
                for (int i = 0; i <= mw; i++) begin
                    if (o == OpLw)
                        push(0, i == mw, o, 1'($urandom),
                             w(3'b000, 0, 2'b00, 0, 0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0), "mem_read");
                    else if (abort_sw && i == mw)
                        push(1, 1, o, 1'($urandom),
                             w(3'b100, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "sw_reset");
                    else
                        push(0, i == mw, o, 1'($urandom),
                             w(3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0), "mem_write");
                end
                if (o == OpLw)
                    push(0, 1'($urandom), o, 1'($urandom),
                         w(3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0), "mem_wb");
            end
            OpR, OpAddi, OpOri, OpLui: begin
                if (o == OpR)
                    push(0, 1'($urandom), o, 1'($urandom),
                         w(3'b111, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "exec_r");
                else
                    push(0, 1'($urandom), o, 1'($urandom),
                         w(o == OpOri ? 3'b101 : (o == OpLui ? 3'b110 : 3'b100), 1, 2'b10,
                           0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "exec_i");
                push(0, 1'($urandom), o, 1'($urandom),
                     w(3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, o == OpR, 0, 0, 0), "alu_wb");
            end
            OpBeq, OpBne:
                push(0, 1'($urandom), o, z,
                     w(3'b011, 1, 2'b00, (o == OpBeq) ? z : !z, 0, 0, 0, 0, 0, 2'b01,
                       0, 0, 0, 0), "branch");
            default: begin
                if (o == OpJal)
                    push(0, 1'($urandom), o, 1'($urandom),
                         w(3'b100, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 1), "jal_link");
                push(0, 1'($urandom), o, 1'($urandom),
                     w(3'b000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0), "jump");
            end
        endcase
    endtask

    task automatic push_instr(input logic [5:0] opc, input logic z, input int fw, input int mw);
        push_fetch(fw);
        push_body(opc, z, mw, 1'b0);
    endtask

    logic [5:0] pool[$] = '{OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpOri, OpLui, OpJ, OpJal};

    initial begin
        step_t s;
        reset = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;

        push(1, 1, 6'h00, 0, w(3'b100, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "reset");
        push(1, 1, 6'h3f, 1, w(3'b100, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "reset");
        push_instr(OpR, 0, 0, 0);
        push_instr(OpLw, 0, 0, 2);
        push_instr(OpBeq, 1, 0, 0);
        push_instr(OpBne, 1, 0, 0);
        push_instr(6'b111111, 0, 0, 0);
        push_fetch(1);
        push_body(OpSw, 0, 2, 1'b1);
        push_instr(OpOri, 0, 0, 0);
        push_instr(OpLui, 0, 0, 0);
        push_instr(OpJal, 0, 0, 0);
        push_instr(OpJ, 0, 1, 0);
        for (int n = 0; n < 200; n++) begin
            logic [5:0] o;
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            else o = pool[$urandom_range(0, pool.size() - 1)];
            push_instr(o, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        while (sched.size() > 0) begin
            s = sched.pop_front();
            reset = s.rst; mem_ready = s.mr; opcode = s.opc; zero = s.z;
            @(negedge clk);
            check_eq(s.tag, obs, s.exp);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
